// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states and port indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    function automatic arb_state_e own_state(input port_idx_t port);
        arb_state_e st;
        if (port == PORT1) begin
            st = OWN1;
        end else begin
            st = OWN0;
        end
        return st;
    endfunction

endpackage

// File: rtl/arb_burst_cnt.sv
// Burst counter for the arbiter: counts grants to the current owner and flags
// when the owner has used its last allowed consecutive grant.
module arb_burst_cnt #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rts,
    input  logic inc,
    input  logic clr,
    output logic wrap
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] count_r;

    // Grant counter; saturates at the limit so an uncontested owner never
    // wraps past the point where a late-arriving requester must be let in.
    always_ff @(posedge clk) begin
        if (rts) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != LAST_CNT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign wrap = (count_r == LAST_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (processor vs. debug/loader) with last-served
// tie breaking, bounded bursts under contention and registered read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rts,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    port_idx_t  last_r;
    logic       wrap_s;
    logic       any_gnt_s;
    logic       own_chg_s;

    // Grants are gated by reset so a reset cycle never touches memory.
    assign p0_gnt    = (state_r == OWN0) & p0_req & ~rts;
    assign p1_gnt    = (state_r == OWN1) & p1_req & ~rts;
    assign p0_stall  = p0_req & ~p0_gnt;
    assign any_gnt_s = p0_gnt | p1_gnt;
    assign own_chg_s = (state_nxt_s != state_r);

    arb_burst_cnt #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_cnt (
        .clk (clk),
        .rts (rts),
        .inc (any_gnt_s),
        .clr (own_chg_s),
        .wrap(wrap_s)
    );

    // Next-state logic: ties from IDLE go to the port not served last.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (p0_req && p1_req) begin
                    state_nxt_s = own_state(~last_r);
                end else if (p0_req) begin
                    state_nxt_s = OWN0;
                end else if (p1_req) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                if (!p0_req) begin
                    state_nxt_s = p1_req ? OWN1 : IDLE;
                end else if (p1_req && wrap_s) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = OWN0;
                end
            end
            OWN1: begin
                if (!p1_req) begin
                    state_nxt_s = p0_req ? OWN0 : IDLE;
                end else if (p0_req && wrap_s) begin
                    state_nxt_s = OWN0;
                end else begin
                    state_nxt_s = OWN1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rts) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Last-served port; resets to port 1 so the processor wins the first tie.
    always_ff @(posedge clk) begin
        if (rts) begin
            last_r <= PORT1;
        end else if (p0_gnt) begin
            last_r <= PORT0;
        end else if (p1_gnt) begin
            last_r <= PORT1;
        end else begin
            last_r <= last_r;
        end
    end

    // Memory-side mux: idle cycles drive zeros so the bus is quiet.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Read-data capture: each port keeps its last read word until the next one.
    always_ff @(posedge clk) begin
        if (rts) begin
            p0_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rdata;
            end else begin
                p0_rdata <= p0_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rdata;
            end else begin
                p1_rdata <= p1_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, write/read, contention bursts,
// early release and reset during a write grant, against a small memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rts;
    logic              p0_req, p0_we, p0_gnt, p0_rvalid, p0_stall;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] mem [32];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rts(rts),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rts = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd0; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 5'd1; p1_wdata = 32'h0;

        // Reset held two cycles with both requests high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
            check("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
            check("rst_mem_we", {31'd0, mem_we}, 32'd0);
            check("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
            check("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
            check("rst_p1_rdata", p1_rdata, 32'd0);
        end
        next_cycle();
        rts = 1'b0;
        @(negedge clk);
        check("post_rst_c1_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        next_cycle();

        // Contention: expect bursts of four, p0 first
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp0 = ((i / 4) % 2) == 0;
            check($sformatf("cont_p0_gnt_%0d", i), {31'd0, p0_gnt}, {31'd0, exp0});
            check($sformatf("cont_p1_gnt_%0d", i), {31'd0, p1_gnt}, {31'd0, ~exp0});
            check($sformatf("cont_stall_%0d", i), {31'd0, p0_stall}, {31'd0, ~exp0});
            next_cycle();
        end

        // Owner and other both drop: bubble, back to idle
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        check("drop_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        check("drop_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();

        // p1 writes 0xDEADBEEF to address 3
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd3; p1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_first_cycle_gnt", {31'd0, p1_gnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("wr_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", {27'd0, mem_addr}, 32'd3);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        p1_we = 1'b0; p1_wdata = 32'h0;
        @(negedge clk);
        check("rd_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        check("rd_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd_mem_word", mem[3], 32'hDEADBEEF);
        next_cycle();
        p1_req = 1'b0;
        @(negedge clk);
        check("rd_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
        check("rd_p1_rdata", p1_rdata, 32'hDEADBEEF);
        check("rd_bubble_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("rd_rvalid_pulse", {31'd0, p1_rvalid}, 32'd0);
        check("rd_rdata_hold", p1_rdata, 32'hDEADBEEF);
        next_cycle();

        // Early release: p0 takes two grants then drops while p1 waits
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd3;
        @(negedge clk);
        check("er_idle_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        next_cycle();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 5'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("er_p0_gnt_%0d", i), {31'd0, p0_gnt}, 32'd1);
            check($sformatf("er_p1_gnt_%0d", i), {31'd0, p1_gnt}, 32'd0);
            next_cycle();
        end
        p0_req = 1'b0;
        @(negedge clk);
        check("er_bubble_p0", {31'd0, p0_gnt}, 32'd0);
        check("er_bubble_p1", {31'd0, p1_gnt}, 32'd0);
        check("er_bubble_we", {31'd0, mem_we}, 32'd0);
        check("er_p0_rdata", p0_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("er_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        next_cycle();

        // Reset during a p1 write grant, with p0 also requesting
        p1_we = 1'b1; p1_wdata = 32'h12345678;
        p0_req = 1'b1; rts = 1'b1;
        @(negedge clk);
        check("mr_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        check("mr_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        rts = 1'b0;
        @(negedge clk);
        check("mr_mem_word", mem[3], 32'hDEADBEEF);
        check("mr_idle_p0_gnt", {31'd0, p0_gnt}, 32'd0);
        check("mr_idle_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        check("mr_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("mr_tie_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        check("mr_tie_p1_gnt", {31'd0, p1_gnt}, 32'd0);
        check("mr_tie_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
